// File: rtl/rr_timer_pkg.sv
// Shared types and constants for the round-robin quantum timer and the
// instruction decoder that drives its arm request.
package rr_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } rr_state_e;

  localparam int unsigned RR_QUANTUM_DEF = 1000;
  localparam int unsigned RR_CNT_W_DEF   = 16;

  // Opcode whose decode produces Atv_Temp.
  localparam logic [5:0] OPC_ROUND_ROBIN = 6'b011011;

endpackage

// File: rtl/rr_down_counter.sv
// Loadable down-counter that saturates at zero and flags the zero value.
// Optional macro RR_TIMER_STATUS_EN exposes the count value.
module rr_down_counter
  import rr_timer_pkg::*;
#(
  parameter int unsigned CNT_W = RR_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
`ifdef RR_TIMER_STATUS_EN
  ,
  output logic [CNT_W-1:0] count_o
`endif
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; a decrement never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

`ifdef RR_TIMER_STATUS_EN
  assign count_o = cnt_q;
`endif

endmodule

// File: rtl/round_robin_timer.sv
// Round-robin quantum timer: forces kernel mode (SO_Kernel) once a quantum
// elapses after arming. Optional macro RR_TIMER_STATUS_EN adds Remaining/Expire_Pulse.
module round_robin_timer
  import rr_timer_pkg::*;
#(
  parameter int unsigned QUANTUM = RR_QUANTUM_DEF,
  parameter int unsigned CNT_W   = RR_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             Atv_Temp,
  output logic             SO_Kernel
`ifdef RR_TIMER_STATUS_EN
  ,
  output logic [CNT_W-1:0] Remaining,
  output logic             Expire_Pulse
`endif
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(QUANTUM - 1);

  rr_state_e state_q, state_d;
  logic      so_q, so_d;
  logic      load_s, dec_s, zero_s, expire_s;

  rr_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load_s),
    .load_val_i (RELOAD),
    .dec_i      (dec_s),
    .zero_o     (zero_s)
`ifdef RR_TIMER_STATUS_EN
    ,
    .count_o    (Remaining)
`endif
  );

  // Next state; an arm request always wins, even on the expiry edge.
  always_comb begin
    state_d  = state_q;
    so_d     = so_q;
    load_s   = 1'b0;
    dec_s    = 1'b0;
    expire_s = 1'b0;
    if (Atv_Temp) begin
      load_s  = 1'b1;
      state_d = RUN;
      so_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          so_d = 1'b0;
        end
        RUN: begin
          if (zero_s) begin
            expire_s = 1'b1;
            state_d  = EXPIRED;
            so_d     = 1'b1;
          end else begin
            dec_s = 1'b1;
          end
        end
        EXPIRED: begin
          so_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          so_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      so_q    <= so_d;
    end
  end

  assign SO_Kernel = so_q;

`ifdef RR_TIMER_STATUS_EN
  logic pulse_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= expire_s;
    end
  end

  assign Expire_Pulse = pulse_q;
`else
  logic unused_s;
  assign unused_s = expire_s;
`endif

endmodule

// File: tb/tb_round_robin_timer.sv
// Scoreboard bench for round_robin_timer: one instance with QUANTUM=4 and one
// with QUANTUM=1 receive identical stimulus and are checked every cycle.
module tb_round_robin_timer;

  logic clk = 1'b0;
  logic reset;
  logic atv;
  logic so4, so1;
`ifdef RR_TIMER_STATUS_EN
  logic [15:0] rem4;
  logic [3:0]  rem1;
  logic        pulse4, pulse1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  round_robin_timer #(.QUANTUM(4), .CNT_W(16)) u_dut4 (
    .clk_i     (clk),
    .reset_i   (reset),
    .Atv_Temp  (atv),
    .SO_Kernel (so4)
`ifdef RR_TIMER_STATUS_EN
    ,
    .Remaining    (rem4),
    .Expire_Pulse (pulse4)
`endif
  );

  round_robin_timer #(.QUANTUM(1), .CNT_W(4)) u_dut1 (
    .clk_i     (clk),
    .reset_i   (reset),
    .Atv_Temp  (atv),
    .SO_Kernel (so1)
`ifdef RR_TIMER_STATUS_EN
    ,
    .Remaining    (rem1),
    .Expire_Pulse (pulse1)
`endif
  );

  typedef struct {
    bit so4;
    bit so1;
    int rem4;
    int rem1;
    bit p4;
    bit p1;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: 0 idle, 1 counting, 2 expired.
  int m4_cnt = 0, m4_st = 0, m1_cnt = 0, m1_st = 0;
  bit m4_so = 1'b0, m1_so = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input int q, input bit r, input bit a,
                            input int cnt_i, input int st_i, input bit so_i,
                            output int cnt_o, output int st_o, output bit so_o,
                            output bit pulse_o);
    cnt_o   = cnt_i;
    st_o    = st_i;
    so_o    = so_i;
    pulse_o = 1'b0;
    if (r) begin
      cnt_o = 0; st_o = 0; so_o = 1'b0;
    end else if (a) begin
      cnt_o = q - 1; st_o = 1; so_o = 1'b0;
    end else if (st_i == 1) begin
      if (cnt_i == 0) begin
        st_o = 2; so_o = 1'b1; pulse_o = 1'b1;
      end else begin
        cnt_o = cnt_i - 1;
      end
    end
  endtask

  // One clock: drive, predict, push; then sample after the edge, pop, compare.
  task automatic step(input bit r, input bit a);
    exp_t e;
    reset = r;
    atv   = a;
    model_step(4, r, a, m4_cnt, m4_st, m4_so, m4_cnt, m4_st, m4_so, e.p4);
    model_step(1, r, a, m1_cnt, m1_st, m1_so, m1_cnt, m1_st, m1_so, e.p1);
    e.so4  = m4_so;
    e.so1  = m1_so;
    e.rem4 = m4_cnt;
    e.rem1 = m1_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk_eq("so4", {31'd0, so4}, {31'd0, e.so4});
      chk_eq("so1", {31'd0, so1}, {31'd0, e.so1});
`ifdef RR_TIMER_STATUS_EN
      chk_eq("rem4", {16'd0, rem4}, e.rem4);
      chk_eq("rem1", {28'd0, rem1}, e.rem1);
      chk_eq("pulse4", {31'd0, pulse4}, {31'd0, e.p4});
      chk_eq("pulse1", {31'd0, pulse1}, {31'd0, e.p1});
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    atv   = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_eq("rst_so4", {31'd0, so4}, 32'd0);
    idle(10);
    chk_eq("idle_so4", {31'd0, so4}, 32'd0);

    // Arm at E0, expiry at E4, held through E20, re-arm at E25, rise at E29.
    step(1'b0, 1'b1);
    idle(3);
    chk_eq("dir_e3", {31'd0, so4}, 32'd0);
    idle(1);
    chk_eq("dir_e4", {31'd0, so4}, 32'd1);
    idle(16);
    chk_eq("dir_e20", {31'd0, so4}, 32'd1);
    idle(4);
    step(1'b0, 1'b1);
    chk_eq("dir_e25", {31'd0, so4}, 32'd0);
    idle(3);
    chk_eq("dir_e28", {31'd0, so4}, 32'd0);
    idle(1);
    chk_eq("dir_e29", {31'd0, so4}, 32'd1);

    // Re-arm at E2 restarts the quantum.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b1);
    idle(2);
    chk_eq("rearm_e4", {31'd0, so4}, 32'd0);
    idle(2);
    chk_eq("rearm_e6", {31'd0, so4}, 32'd1);

    // Re-arm coincident with expiry wins.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(3);
    step(1'b0, 1'b1);
    chk_eq("coinc_e4", {31'd0, so4}, 32'd0);
    idle(3);
    chk_eq("coinc_e7", {31'd0, so4}, 32'd0);
    idle(1);
    chk_eq("coinc_e8", {31'd0, so4}, 32'd1);

    // Reset mid-run aborts; reset while expired drops SO_Kernel.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b0);
    idle(6);
    chk_eq("abort_so4", {31'd0, so4}, 32'd0);
    step(1'b0, 1'b1);
    idle(5);
    chk_eq("pre_rst_so4", {31'd0, so4}, 32'd1);
    step(1'b1, 1'b0);
    chk_eq("rst_exp_so4", {31'd0, so4}, 32'd0);

    // QUANTUM=1 instance: rise one edge after arming; held arm delays expiry.
    step(1'b0, 1'b1);
    idle(1);
    chk_eq("q1_e1", {31'd0, so1}, 32'd1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      chk_eq("q1_hold", {31'd0, so1}, 32'd0);
    end
    idle(1);
    chk_eq("q1_e6", {31'd0, so1}, 32'd1);

    // Random arm/reset traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
